// File: rtl/uart_rx_pair.sv
// uart_rx_pair: two-frame 8N1 UART receiver with glitch rejection, framing check and optional inter-byte timeout (UARTRX_TIMEOUT_EN)
module uart_rx_pair #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxd,
    output logic [7:0] first_byte,
    output logic [7:0] second_byte,
    output logic       Valid,
    output logic       Frame_err,
    output logic       Timeout_err,
    output logic       Busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK, GAP} state_t;

    if (CLKS_PER_BIT < 4 || TIMEOUT_BITS < 1) begin : g_param_check
        $error("uart_rx_pair: CLKS_PER_BIT must be >= 4 and TIMEOUT_BITS >= 1");
    end

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rxd_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_i, bit_n;
    logic          idx, idx_n;
    logic [7:0]    sh, sh_n, b0, b0_n, fb_n, sb_n;
    logic          v_n, fe_n;

    assign rxd_s = sync[1];
    assign Busy  = (state != IDLE);

`ifdef UARTRX_TIMEOUT_EN
    localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW = $clog2(TO);
    logic [GW-1:0] gap;
    logic          to_n;

    // GAP dwell counter, cleared whenever the FSM is outside GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            gap         <= '0;
            Timeout_err <= 1'b0;
        end else begin
            gap         <= (state == GAP) ? gap + GW'(1) : '0;
            Timeout_err <= to_n;
        end
    end
`else
    assign Timeout_err = 1'b0;
`endif

    // Two-flop synchroniser (idle high) and all receiver state/outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync        <= 2'b11;
            state       <= IDLE;
            cnt         <= '0;
            bit_i       <= '0;
            idx         <= 1'b0;
            sh          <= '0;
            b0          <= '0;
            first_byte  <= '0;
            second_byte <= '0;
            Valid       <= 1'b0;
            Frame_err   <= 1'b0;
        end else begin
            sync        <= {sync[0], Rxd};
            state       <= state_n;
            cnt         <= cnt_n;
            bit_i       <= bit_n;
            idx         <= idx_n;
            sh          <= sh_n;
            b0          <= b0_n;
            first_byte  <= fb_n;
            second_byte <= sb_n;
            Valid       <= v_n;
            Frame_err   <= fe_n;
        end
    end

    // Next-state: mid-bit sampling, byte pairing, break hold and gap timeout
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        bit_n   = bit_i;
        idx_n   = idx;
        sh_n    = sh;
        b0_n    = b0;
        fb_n    = first_byte;
        sb_n    = second_byte;
        v_n     = 1'b0;
        fe_n    = 1'b0;
`ifdef UARTRX_TIMEOUT_EN
        to_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bit_n   = '0;
                    state_n = rxd_s ? (idx ? GAP : IDLE) : DATA;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n       = '0;
                    sh_n[bit_i] = rxd_s;
                    bit_n       = bit_i + 3'd1;
                    if (bit_i == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (!rxd_s) begin
                        fe_n    = 1'b1;
                        idx_n   = 1'b0;
                        state_n = BREAK;
                    end else if (!idx) begin
                        b0_n    = sh;
                        idx_n   = 1'b1;
                        state_n = GAP;
                    end else begin
                        fb_n    = b0;
                        sb_n    = sh;
                        v_n     = 1'b1;
                        idx_n   = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rxd_s) state_n = IDLE;
            end
            GAP: begin
                cnt_n = '0;
                if (!rxd_s) state_n = START;
`ifdef UARTRX_TIMEOUT_EN
                else if (gap == GW'(TO - 1)) begin
                    to_n    = 1'b1;
                    idx_n   = 1'b0;
                    state_n = IDLE;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_pair.sv
// tb_uart_rx_pair: scoreboard bench for uart_rx_pair (CLKS_PER_BIT=16, TIMEOUT_BITS=4)
module tb_uart_rx_pair;
    localparam int N = 16;

    logic       clk, rst, Rxd;
    logic [7:0] first_byte, second_byte;
    logic       Valid, Frame_err, Timeout_err, Busy;

    int passed = 0, total = 0;
    int cyc = 0, t_start = 0, t0 = 0, vcyc = 0, tcyc = 0;
    int nv = 0, nfe = 0, nto = 0;
    logic [15:0] exp_q[$];

    uart_rx_pair #(.CLKS_PER_BIT(N), .TIMEOUT_BITS(4)) dut (
        .clk(clk), .rst(rst), .Rxd(Rxd),
        .first_byte(first_byte), .second_byte(second_byte),
        .Valid(Valid), .Frame_err(Frame_err), .Timeout_err(Timeout_err), .Busy(Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (Valid | Frame_err | Timeout_err)
                check("excl", 32'(Valid) + 32'(Frame_err) + 32'(Timeout_err), 1);
            if (Valid) begin
                nv++;
                vcyc = cyc;
                check("busy_at_valid", 32'(Busy), 0);
                if (exp_q.size() == 0) check("pair_expected", exp_q.size(), 1);
                else check("pair", {first_byte, second_byte}, exp_q.pop_front());
            end
            if (Frame_err) nfe++;
            if (Timeout_err) begin
                nto++;
                tcyc = cyc;
            end
        end
    end

    task automatic bit_period(input logic v);
        @(negedge clk);
        Rxd = v;
        repeat (N - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        Rxd = 1'b0;
        t_start = cyc;
        repeat (N - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) bit_period(d[i]);
        bit_period(stop);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        Rxd = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        Rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        nv = 0;
        nfe = 0;
        nto = 0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        Rxd = 1'b1;
        do_reset();
        check("rst_bytes", {first_byte, second_byte}, 0);
        check("rst_flags", {Valid, Frame_err, Timeout_err, Busy}, 0);

        exp_q.push_back(16'hA53C);
        send_byte(8'hA5, 1'b1);
        t0 = t_start;
        send_byte(8'h3C, 1'b1);
        idle(3 * N);
        check("b2b_nv", nv, 1);
        check("b2b_nfe", nfe, 0);
        check("b2b_nto", nto, 0);
        check("b2b_lat", vcyc - t0, 315);
        idle(50);
        check("b2b_hold", {first_byte, second_byte}, 16'hA53C);

        do_reset();
        @(negedge clk);
        Rxd = 1'b0;
        repeat (4) @(negedge clk);
        Rxd = 1'b1;
        for (int i = 0; i < 10 && Busy; i++) @(negedge clk);
        check("glitch_busy", 32'(Busy), 0);
        idle(2 * N);
        check("glitch_nv", nv, 0);
        check("glitch_nfe", nfe, 0);

        do_reset();
        send_byte(8'h55, 1'b0);
        @(negedge clk);
        Rxd = 1'b0;
        repeat (39) @(negedge clk);
        check("brk_busy", 32'(Busy), 1);
        check("brk_nfe", nfe, 1);
        check("brk_nv", nv, 0);
        idle(N);
        exp_q.push_back(16'h0102);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(3 * N);
        check("brk_pair_nv", nv, 1);
        check("brk_pair_nfe", nfe, 1);

        do_reset();
`ifdef UARTRX_TIMEOUT_EN
        exp_q.push_back(16'h2233);
`else
        exp_q.push_back(16'h1122);
`endif
        send_byte(8'h11, 1'b1);
        t0 = t_start;
        idle(80);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(3 * N);
        check("to_nv", nv, 1);
`ifdef UARTRX_TIMEOUT_EN
        check("to_nto", nto, 1);
        check("to_when", tcyc - t0, 219);
`else
        check("to_nto", nto, 0);
`endif

        do_reset();
        bit_period(1'b0);
        for (int i = 0; i < 3; i++) bit_period(1'b1);
        @(negedge clk);
        Rxd = 1'b0;
        repeat (N / 2) @(negedge clk);
        check("abort_busy_pre", 32'(Busy), 1);
        rst = 1'b1;
        Rxd = 1'b1;
        @(negedge clk);
        check("abort_outs", {first_byte, second_byte, Valid, Frame_err, Timeout_err, Busy}, 0);
        rst = 1'b0;
        idle(N);
        exp_q.push_back(16'hFF00);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        idle(3 * N);
        check("abort_nv", nv, 1);
        check("abort_nfe", nfe, 0);

        do_reset();
        exp_q.push_back(16'h807E);
        send_byte(8'h80, 1'b1);
        idle(3 * N);
        send_byte(8'h7E, 1'b1);
        idle(3 * N);
        check("gap_nv", nv, 1);
        check("gap_nto", nto, 0);
        check("q_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
